// File: rtl/rpn_stack_ctrl.sv
// Operand-stack sequencer for the RPN calculator: accepts push/operate/drop/clear
// commands and time-shares an external combinational ALU over an IDLE/EXEC/WB cycle.
module rpn_stack_ctrl #(
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_type,
  input  logic [31:0]                  cmd_data,
  input  logic [3:0]                   cmd_op,
  output logic [31:0]                  alu_a,
  output logic [31:0]                  alu_b,
  output logic [3:0]                   alu_op,
  output logic [4:0]                   alu_shamt,
  input  logic [31:0]                  alu_hi,
  input  logic [31:0]                  alu_lo,
  input  logic                         alu_zero,
  output logic [31:0]                  top,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic [31:0]                  hi_reg,
  output logic                         zero_flag,
  output logic                         done,
  output logic                         err_underflow,
  output logic                         err_overflow
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  localparam logic [1:0] CMD_PUSH = 2'b00;
  localparam logic [1:0] CMD_OP   = 2'b01;
  localparam logic [1:0] CMD_DROP = 2'b10;
  localparam logic [1:0] CMD_CLR  = 2'b11;

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [31:0]     r_stack [DEPTH];
  logic [DW-1:0]   r_depth;
  logic [31:0]     r_result_lo;
  logic [31:0]     r_hi;
  logic            r_zero;
  logic            r_done;
  logic            r_err_uf;
  logic            r_err_of;
  logic [31:0]     r_alu_a;
  logic [31:0]     r_alu_b;
  logic [3:0]      r_alu_op;
  logic [4:0]      r_alu_shamt;

  logic            w_accept;
  logic            w_has_room;
  logic            w_has_two;
  logic [DW-1:0]   w_depth_m1;
  logic [DW-1:0]   w_depth_m2;
  logic            w_we;
  logic [IW-1:0]   w_waddr;
  logic [31:0]     w_wdata;

  assign cmd_ready  = (r_state == IDLE);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_has_room = (r_depth < DW'(DEPTH));
  assign w_has_two  = (r_depth >= DW'(2));
  assign w_depth_m1 = r_depth - DW'(1);
  assign w_depth_m2 = r_depth - DW'(2);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && cmd_type == CMD_OP && w_has_two) w_state_next = EXEC;
      EXEC:    w_state_next = WB;
      WB:      w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Single write port: a push in IDLE or the operate result in WB, never both.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_depth[IW-1:0];
    w_wdata = cmd_data;
    if (r_state == WB) begin
      w_we    = 1'b1;
      w_waddr = w_depth_m2[IW-1:0];
      w_wdata = r_result_lo;
    end else if (w_accept && cmd_type == CMD_PUSH && w_has_room) begin
      w_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_stack[w_waddr] <= w_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_depth     <= '0;
      r_result_lo <= '0;
      r_hi        <= '0;
      r_zero      <= 1'b0;
      r_done      <= 1'b0;
      r_err_uf    <= 1'b0;
      r_err_of    <= 1'b0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_alu_shamt <= '0;
    end else begin
      // Registered so the pulse lines up with the WB cycle.
      r_done <= (r_state == EXEC);
      if (w_accept) begin
        case (cmd_type)
          CMD_PUSH: begin
            if (w_has_room) r_depth <= r_depth + DW'(1);
            else            r_err_of <= 1'b1;
          end
          CMD_OP: begin
            if (w_has_two) begin
              r_alu_a     <= r_stack[w_depth_m2[IW-1:0]];
              r_alu_b     <= r_stack[w_depth_m1[IW-1:0]];
              r_alu_op    <= cmd_op;
              r_alu_shamt <= cmd_data[4:0];
            end else begin
              r_err_uf <= 1'b1;
            end
          end
          CMD_DROP: begin
            if (r_depth != '0) r_depth <= w_depth_m1;
            else               r_err_uf <= 1'b1;
          end
          default: begin
            r_depth  <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b0;
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
          end
        endcase
      end
      if (r_state == EXEC) begin
        r_result_lo <= alu_lo;
        r_hi        <= alu_hi;
        r_zero      <= alu_zero;
      end
      if (r_state == WB) r_depth <= w_depth_m1;
    end
  end

  assign top           = (r_depth == '0) ? 32'd0 : r_stack[w_depth_m1[IW-1:0]];
  assign depth         = r_depth;
  assign hi_reg        = r_hi;
  assign zero_flag     = r_zero;
  assign done          = r_done;
  assign err_underflow = r_err_uf;
  assign err_overflow  = r_err_of;
  assign alu_a         = r_alu_a;
  assign alu_b         = r_alu_b;
  assign alu_op        = r_alu_op;
  assign alu_shamt     = r_alu_shamt;

endmodule

// File: doc/rpn_stack_ctrl.md
# rpn_stack_ctrl

Command-driven sequencer that owns the operand stack of the RPN calculator and time-shares the shared combinational ALU between stack operations. Accepts push, operate, drop and clear commands over a valid/ready handshake. Pops operands into registered ALU inputs, captures the ALU result and pushes it back. Reports depth, top-of-stack, the mult high word and sticky error flags to the display/host side.

## Interface
- DEPTH, 8: stack entries (2..16); data width fixed at 32.
- clk  in  1  single clock, all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_type  in  2  00 push, 01 operate, 10 drop, 11 clear.
- cmd_data  in  32  push value; for operate, [4:0] is the shift amount.
- cmd_op  in  4  ALU opcode for operate (ALU encoding, passed through unchanged).
- alu_a, alu_b  out  32  registered operands: a = next-on-stack (NOS), b = top-of-stack (TOS).
- alu_op  out  4  registered opcode.
- alu_shamt  out  5  registered shift amount.
- alu_hi, alu_lo  in  32  ALU results.
- alu_zero  in  1  ALU lo==0 flag.
- top  out  32  stack[depth-1]; 0 when empty.
- depth  out  $clog2(DEPTH+1)  current entry count.
- hi_reg  out  32  high word of the last operate.
- zero_flag  out  1  alu_zero captured at the last writeback.
- done  out  1  one-cycle pulse on operate writeback.
- err_underflow, err_overflow  out  1  sticky error flags.

## Operation
- States: IDLE, EXEC, WB. cmd_ready = (state==IDLE). A command is accepted when cmd_valid & cmd_ready.
- Push, IDLE:
  - depth<DEPTH: stack[depth]<=cmd_data, depth+1.
  - depth==DEPTH: stack unchanged, err_overflow<=1.
  - Stay IDLE.
- Drop, IDLE:
  - depth>0: depth-1.
  - depth==0: err_underflow<=1.
  - Stay IDLE.
- Clear, IDLE: depth<=0, hi_reg<=0, zero_flag<=0, both error flags <=0. Stay IDLE.
- Operate, IDLE:
  - depth<2: no stack change, err_underflow<=1, stay IDLE.
  - Otherwise: alu_a<=stack[depth-2], alu_b<=stack[depth-1], alu_op<=cmd_op, alu_shamt<=cmd_data[4:0], go to EXEC.
- EXEC: the ALU evaluates the registered operands. Capture result_lo<=alu_lo, hi_reg<=alu_hi, zero_flag<=alu_zero. Go to WB.
- WB: stack[depth-2]<=result_lo, depth-1, done<=1. Go to IDLE.
- Operate always consumes 2 entries and produces 1, so it never overflows.
- hi_reg takes alu_hi for every operate; the ALU drives 0 for non-mult ops, so hi_reg reads 0 after them.
- alu_* outputs hold their last value outside EXEC.
- Errors are sticky. Only Clear or reset clears them. An error never blocks later commands.
- Entries at index ≥ depth are don't-care. top reads stack[depth-1] combinationally, or 0 when depth==0.

## Timing
- Reset (rst_n low at an edge): state IDLE, depth 0, top 0, hi_reg 0, zero_flag 0, done 0, both errors 0, alu_a/alu_b 0, alu_op 0, alu_shamt 0. cmd_ready is 1 in the first cycle after reset deasserts.
- Reset mid-operation (in EXEC or WB) aborts the operation with no writeback and no done pulse. Reset wins over any simultaneous command.
- Push, drop, clear: one accept per cycle, back-to-back. The result is visible on top/depth the cycle after accept.
- Operate, accepted at edge N:
  - EXEC during cycle N+1.
  - WB during cycle N+2, with done high during N+2.
  - top, depth and hi_reg show the result from cycle N+3; cmd_ready returns high in N+3.
  - Throughput: one operate per 3 cycles.
- cmd_ready is low in EXEC and WB. Commands presented then are not accepted; the host holds cmd_valid and the command fields stable until accepted.

## Test plan
- Reset, then push 7, push 5, operate op=0101 (sub) at edge N → done high at N+2; top=2, depth=1, hi_reg=0 at N+3.
- Push 0xFFFFFFFD (-3), push 4, operate op=0110 (signed mult) → top=0xFFFFFFF4, hi_reg=0xFFFFFFFF. Clear → depth 0, hi_reg 0.
- Push 0, push 1, operate op=1000 with cmd_data=4 → alu_shamt=4, top=0x10. Then push 0x10, operate op=0101 → top=0, zero_flag=1.
- depth=1, operate → err_underflow=1, depth stays 1, cmd_ready stays high, no done pulse. Drop twice → depth 0, err_underflow still 1. Clear → err_underflow=0.
- Push 1..9 back-to-back with DEPTH=8 → depth=8, top=8, err_overflow=1. Then operate op=0100 (add) → top=15, depth=7.
- Push 3, push 4, operate op=0100 (add), assert rst_n low during EXEC → no done pulse; depth 0, top 0, cmd_ready high the cycle after rst_n rises.
